pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Controller that owns the program counter of the single-cycle RISC-V core: holds the PC register, selects the next PC (sequential, branch, JAL, JALR, trap), and gates advancement with a post-reset boot delay, a pipeline stall and an instruction-fetch ready handshake. It sits between the decode/branch-compare logic and the instruction ROM address port, and also provides an advance counter.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value loaded by reset.
- `TRAP_VEC`, 32'h0000_0100: PC loaded on trap (and on misaligned target when enabled).
- `BOOT_DELAY`, 1: cycles after reset release during which the PC holds at `RESET_PC` (range 1–15).
- `clk`  in  1: clock, rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `stall_i`  in  1: hold PC this cycle.
- `fetch_ready_i`  in  1: instruction memory accepts the address on `pc_o`.
- `br_taken_i`  in  1: conditional branch resolved taken.
- `jal_i`  in  1: JAL in current instruction.
- `jalr_i`  in  1: JALR in current instruction.
- `trap_i`  in  1: exception/ecall request.
- `imm_i`  in  32: sign-extended immediate.
- `rs1_i`  in  32: rs1 operand for JALR.
- `pc_o`  out  32: current PC (registered).
- `pc4_o`  out  32: `pc_o + 4` (combinational, for link register).
- `fetch_req_o`  out  1: address on `pc_o` is valid for fetch.
- `misalign_o`  out  1: selected redirect target has bits[1:0] != 0 (combinational).
- `adv_cnt_o`  out  32: number of PC updates since reset.

## Operation
- States: BOOT, RUN. Reset -> BOOT with boot counter = 0.
- BOOT: PC holds at `RESET_PC`, `fetch_req_o`=0, all control inputs ignored; counter increments each cycle; when counter reaches `BOOT_DELAY`-1 the next state is RUN.
- RUN: `fetch_req_o`=1. PC updates at the clock edge when `advance` = trap_i OR (!stall_i AND fetch_ready_i).
- Next-PC priority (first match): trap_i -> `TRAP_VEC`; jalr_i -> (rs1_i + imm_i) & ~32'h1; jal_i -> pc_o + imm_i; br_taken_i -> pc_o + imm_i; else pc_o + 4.
- Trap overrides stall and fetch_ready_i; all other sources are ignored while held.
- All adds are 32-bit, wrap modulo 2^32 (e.g. 32'hFFFF_FFFC + 4 = 32'h0).
- `misalign_o` evaluates only the jalr/jal/branch target actually selected; 0 when sequential or trap selected.
- `adv_cnt_o` increments by 1 on each RUN-state update, wraps at 2^32, never counts BOOT cycles.
- No other state; no return from RUN except reset.

## Timing
- Reset values: `pc_o`=`RESET_PC`, `fetch_req_o`=0, `adv_cnt_o`=0, state BOOT; `pc4_o`=`RESET_PC`+4, `misalign_o`=0 under reset.
- Reset asserted mid-operation clears state immediately (asynchronous), regardless of clock.
- With `BOOT_DELAY`=1: reset deasserts before edge 0; edge 0 enters RUN with PC unchanged; first PC change at edge 1.
- Redirect latency: inputs sampled at edge N, new `pc_o` visible after edge N; no bubble.
- `fetch_req_o` registered; rises on the same edge that enters RUN.

## Configuration
- `PC_MISALIGN_TRAP_EN` defined: when `misalign_o`=1 and the PC would advance, the PC loads `TRAP_VEC` instead of the misaligned target; counts as one advance.
- Not defined: misaligned target is loaded as computed (JALR bit 0 still cleared); `misalign_o` remains a status output only.

## Test plan
- Reset with `BOOT_DELAY`=3, no stall -> `pc_o`=0 for edges 0–2, `fetch_req_o` rises at edge 2, `pc_o`=4 after edge 3, `adv_cnt_o`=1.
- RUN at pc=0x40, jalr_i=1, rs1_i=0x1001, imm_i=0x10, br_taken_i=1 -> `pc_o`=0x1010 (JALR wins, bit 0 cleared), `pc4_o` was 0x44.
- pc=0x80, stall_i=1 with jal_i=1 imm 0x20 for 2 cycles, then stall_i=0 -> `pc_o`=0x80 for 2 edges, then 0xA0; `adv_cnt_o` +1 only.
- pc=0x80, fetch_ready_i=0, trap_i=1 -> `pc_o`=0x100 next edge; fetch_ready_i=0 alone -> hold.
- pc=0xFFFF_FFFC sequential -> `pc_o`=0x0; branch imm_i=0xFFFF_FFF8 from 0x10 -> 0x8.
- pc=0x20, jal_i=1, imm_i=0x6 -> `misalign_o`=1; with `PC_MISALIGN_TRAP_EN` `pc_o`=0x100, without `pc_o`=0x26.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter owner for the single-cycle RISC-V core.
// Holds the PC and selects the next PC from trap, JALR, JAL, branch and
// sequential sources. Advancement is gated by a post-reset boot delay, a stall
// and the fetch-ready handshake. Also counts PC advances.
// Optional feature macro: PC_MISALIGN_TRAP_EN (a misaligned redirect target
// loads TRAP_VEC instead of the target).
module pc_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC   = 32'h0000_0100,
  parameter int unsigned BOOT_DELAY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        fetch_ready_i,
  input  logic        br_taken_i,
  input  logic        jal_i,
  input  logic        jalr_i,
  input  logic        trap_i,
  input  logic [31:0] imm_i,
  input  logic [31:0] rs1_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc4_o,
  output logic        fetch_req_o,
  output logic        misalign_o,
  output logic [31:0] adv_cnt_o
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_DELAY - 1);

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] boot_cnt, boot_cnt_d;
  logic [XLEN-1:0]  pc_d;
  logic [XLEN-1:0]  adv_cnt_d;
  logic             fetch_req_d;
  logic [XLEN-1:0]  target;
  logic             redirect;
  logic             advance;
  logic             target_misaligned;

  // Next-PC candidate selection by fixed priority.
  always_comb begin
    target   = pc_o + XLEN'(4);
    redirect = 1'b0;
    if (trap_i) begin
      target = TRAP_VEC;
    end else if (jalr_i) begin
      target   = (rs1_i + imm_i) & ~XLEN'(1);
      redirect = 1'b1;
    end else if (jal_i || br_taken_i) begin
      target   = pc_o + imm_i;
      redirect = 1'b1;
    end
  end

  assign target_misaligned = redirect && (target[1:0] != 2'b00);
  assign misalign_o        = (state == RUN) && target_misaligned;
  assign pc4_o             = pc_o + XLEN'(4);
  assign advance           = trap_i || (!stall_i && fetch_ready_i);

  // Next-state and registered-output values.
  always_comb begin
    state_d     = state;
    boot_cnt_d  = boot_cnt;
    pc_d        = pc_o;
    fetch_req_d = fetch_req_o;
    adv_cnt_d   = adv_cnt_o;
    case (state)
      BOOT: begin
        pc_d        = RESET_PC;
        fetch_req_d = 1'b0;
        boot_cnt_d  = boot_cnt + CNT_W'(1);
        if (boot_cnt == BOOT_LAST) begin
          state_d     = RUN;
          fetch_req_d = 1'b1;
        end
      end
      RUN: begin
        fetch_req_d = 1'b1;
        if (advance) begin
          adv_cnt_d = adv_cnt_o + XLEN'(1);
`ifdef PC_MISALIGN_TRAP_EN
          pc_d = target_misaligned ? TRAP_VEC : target;
`else
          pc_d = target;
`endif
        end
      end
      default: begin
        state_d     = BOOT;
        fetch_req_d = 1'b0;
      end
    endcase
  end

  // State, PC, fetch request and advance counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT;
      boot_cnt    <= '0;
      pc_o        <= RESET_PC;
      fetch_req_o <= 1'b0;
      adv_cnt_o   <= '0;
    end else begin
      state       <= state_d;
      boot_cnt    <= boot_cnt_d;
      pc_o        <= pc_d;
      fetch_req_o <= fetch_req_d;
      adv_cnt_o   <= adv_cnt_d;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios with literal
// expectations plus randomized traffic against a behavioural PC model.
module tb_pc_sequencer;

  localparam int unsigned D        = 3;
  localparam logic [31:0] RST_PC   = 32'h0000_0000;
  localparam logic [31:0] TRAP_PC  = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, ready, br, jal, jalr, trap;
  logic [31:0] imm, rs1;
  logic [31:0] pc, pc4, adv;
  logic        fetch_req, misalign;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state: edges since reset release, PC, advance count.
  int          m_edges;
  logic [31:0] m_pc;
  logic [31:0] m_cnt;

  pc_sequencer #(.RESET_PC(RST_PC), .TRAP_VEC(TRAP_PC), .BOOT_DELAY(D)) dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall), .fetch_ready_i(ready),
    .br_taken_i(br), .jal_i(jal), .jalr_i(jalr), .trap_i(trap),
    .imm_i(imm), .rs1_i(rs1), .pc_o(pc), .pc4_o(pc4),
    .fetch_req_o(fetch_req), .misalign_o(misalign), .adv_cnt_o(adv)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic s, input logic r, input logic b, input logic j,
                        input logic jr, input logic t, input logic [31:0] im,
                        input logic [31:0] rs);
    stall = s; ready = r; br = b; jal = j; jalr = jr; trap = t; imm = im; rs1 = rs;
  endtask

  task automatic model_reset();
    m_edges = 0;
    m_pc    = RST_PC;
    m_cnt   = 32'd0;
  endtask

  // Compare current outputs to the model, then advance the model and the clock.
  task automatic cycle();
    logic        run, redir, mis, adv_now;
    logic [31:0] tgt;
    #1;
    run   = (m_edges >= int'(D));
    redir = 1'b0;
    tgt   = m_pc + 32'd4;
    if (trap)              tgt = TRAP_PC;
    else if (jalr)         begin tgt = (rs1 + imm) & 32'hFFFF_FFFE; redir = 1'b1; end
    else if (jal || br)    begin tgt = m_pc + imm; redir = 1'b1; end
    mis     = run && redir && (tgt[1:0] != 2'b00);
    adv_now = run && (trap || (!stall && ready));
    chk("pc_o", pc, m_pc);
    chk("pc4_o", pc4, m_pc + 32'd4);
    chk("fetch_req_o", 32'(fetch_req), 32'(run));
    chk("misalign_o", 32'(misalign), 32'(mis));
    chk("adv_cnt_o", adv, m_cnt);
    if (adv_now) begin
`ifdef PC_MISALIGN_TRAP_EN
      m_pc = mis ? TRAP_PC : tgt;
`else
      m_pc = tgt;
`endif
      m_cnt = m_cnt + 32'd1;
    end
    @(posedge clk);
    m_edges++;
    @(negedge clk);
  endtask

  // Load an arbitrary PC via an aligned JALR.
  task automatic goto_pc(input logic [31:0] target);
    set_in(0, 1, 0, 0, 1, 0, 32'd0, target);
    cycle();
  endtask

  initial begin
    logic [31:0] a0;
    rst_n = 1'b0;
    set_in(0, 1, 0, 0, 0, 0, 32'd0, 32'd0);
    repeat (2) @(negedge clk);
    chk("rst pc_o", pc, 32'h0);
    chk("rst pc4_o", pc4, 32'h4);
    chk("rst fetch_req_o", 32'(fetch_req), 32'd0);
    chk("rst misalign_o", 32'(misalign), 32'd0);
    chk("rst adv_cnt_o", adv, 32'd0);

    // Boot delay of 3: PC holds for edges 0-2, fetch_req rises at edge 2.
    rst_n = 1'b1;
    model_reset();
    set_in(0, 1, 1, 1, 1, 1, 32'h40, 32'h80);  // ignored while booting
    cycle();
    chk("boot e0 pc", pc, 32'h0);
    chk("boot e0 req", 32'(fetch_req), 32'd0);
    cycle();
    chk("boot e1 req", 32'(fetch_req), 32'd0);
    set_in(0, 1, 0, 0, 0, 0, 32'd0, 32'd0);
    cycle();
    chk("boot e2 pc", pc, 32'h0);
    chk("boot e2 req", 32'(fetch_req), 32'd1);
    cycle();
    chk("boot e3 pc", pc, 32'h4);
    chk("boot e3 adv", adv, 32'd1);

    // JALR beats branch; bit 0 cleared.
    goto_pc(32'h40);
    set_in(0, 1, 1, 0, 1, 0, 32'h10, 32'h1001);
    #1 chk("pc4 at 0x40", pc4, 32'h44);
    cycle();
    chk("jalr pc", pc, 32'h1010);

    // Stall holds JAL for two edges, then it lands; one advance.
    goto_pc(32'h80);
    a0 = adv;
    set_in(1, 1, 0, 1, 0, 0, 32'h20, 32'd0);
    cycle();
    chk("stall1 pc", pc, 32'h80);
    cycle();
    chk("stall2 pc", pc, 32'h80);
    stall = 1'b0;
    cycle();
    chk("jal after stall", pc, 32'hA0);
    chk("stall adv +1", adv, a0 + 32'd1);

    // Trap overrides fetch_ready low; fetch_ready low alone holds.
    goto_pc(32'h80);
    set_in(0, 0, 0, 0, 0, 1, 32'd0, 32'd0);
    cycle();
    chk("trap no ready", pc, 32'h100);
    trap = 1'b0;
    cycle();
    chk("not ready hold", pc, 32'h100);

    // Wrap-around sequential and negative branch.
    goto_pc(32'hFFFF_FFFC);
    set_in(0, 1, 0, 0, 0, 0, 32'd0, 32'd0);
    cycle();
    chk("seq wrap", pc, 32'h0);
    goto_pc(32'h10);
    set_in(0, 1, 1, 0, 0, 0, 32'hFFFF_FFF8, 32'd0);
    cycle();
    chk("neg branch", pc, 32'h8);

    // Misaligned JAL target.
    goto_pc(32'h20);
    set_in(0, 1, 0, 1, 0, 0, 32'h6, 32'd0);
    #1 chk("misalign flag", 32'(misalign), 32'd1);
    cycle();
`ifdef PC_MISALIGN_TRAP_EN
    chk("misalign target", pc, 32'h100);
`else
    chk("misalign target", pc, 32'h26);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] r_imm;
      r_imm = ($urandom_range(0, 7) == 0) ? $urandom : (32'($urandom_range(0, 64)) << 2) - 32'd128;
      if ($urandom_range(0, 9) == 0) r_imm = r_imm | 32'(($urandom_range(1, 3)));
      set_in(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) != 0),
             1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 5) == 0),
             1'($urandom_range(0, 6) == 0), 1'($urandom_range(0, 15) == 0),
             r_imm, ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 : $urandom);
      cycle();
    end

    // Asynchronous reset mid-cycle clears immediately.
    #2 rst_n = 1'b0;
    #1;
    chk("async rst pc", pc, 32'h0);
    chk("async rst adv", adv, 32'd0);
    chk("async rst req", 32'(fetch_req), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    set_in(0, 1, 0, 0, 0, 0, 32'd0, 32'd0);
    repeat (6) cycle();
    chk("post rst pc", pc, 32'h0C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
